// File: rtl/vga_frame_buffer_if.sv
// Bus-mapped bridge to the VGA generator: frame buffer, colour register and a clear/fill engine.
// Port A is shared by bus pixel access and the fill engine; port B feeds the VGA read side.
module vga_frame_buffer_if #(
    parameter logic [7:0]  BASE_ADDR    = 8'hB0,
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter logic [15:0] COLOUR_RESET = 16'hFF00
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            BUS_ADDR,
    input  logic [7:0]            BUS_DATA_IN,
    input  logic                  BUS_WE,
    input  logic                  BUS_RE,
    output logic [7:0]            BUS_DATA_OUT,
    output logic                  BUS_DATA_OE,
    input  logic                  DPR_CLK,
    input  logic [ADDR_WIDTH-1:0] VGA_ADDR,
    output logic                  VGA_DATA,
    output logic [15:0]           CONFIG_COLOURS,
    output logic                  FILL_BUSY
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CntLast = '1;

    typedef enum logic {StIdle, StFill} state_t;

    state_t                r_state;
    logic                  r_fill_busy;
    logic                  r_fill_val;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [7:0]            r_x;
    logic [6:0]            r_y;
    logic [15:0]           r_colours;
    logic [7:0]            r_dout;
    logic                  r_oe;
    logic                  r_vga;
    logic                  r_mem [Depth];

    logic [7:0]            w_offset;
    logic                  w_in_range;
    logic                  w_wr;
    logic                  w_rd;
    logic [14:0]           w_yx;
    logic [ADDR_WIDTH-1:0] w_pix_addr;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_din;
    logic [7:0]            w_rd_data;

    assign w_offset   = BUS_ADDR - BASE_ADDR;
    assign w_in_range = (w_offset < 8'd6);
    assign w_wr       = BUS_WE & w_in_range;
    // A simultaneous write wins; the read is dropped.
    assign w_rd       = BUS_RE & ~BUS_WE & w_in_range;
    assign w_yx       = {r_y, r_x};
    assign w_pix_addr = w_yx[ADDR_WIDTH-1:0];

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = w_pix_addr;
        w_mem_din  = BUS_DATA_IN[0];
        if (!RESET) begin
            if (r_state == StFill) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_fill_cnt;
                w_mem_din  = r_fill_val;
            end else if (w_wr && (w_offset == 8'd2)) begin
                w_mem_we   = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        unique case (w_offset)
            8'd0:    w_rd_data = r_x;
            8'd1:    w_rd_data = {1'b0, r_y};
            8'd2:    w_rd_data = r_fill_busy ? 8'h00 : {7'b0, r_mem[w_pix_addr]};
            8'd3:    w_rd_data = r_colours[7:0];
            8'd4:    w_rd_data = r_colours[15:8];
            8'd5:    w_rd_data = {7'b0, r_fill_busy};
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Nonblocking read gives old data on a same-address collision with port A.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vga <= 1'b0;
        end else if (DPR_CLK) begin
            r_vga <= r_mem[VGA_ADDR];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_fill_busy <= 1'b0;
            r_fill_val  <= 1'b0;
            r_fill_cnt  <= '0;
        end else if (r_state == StIdle) begin
            if (w_wr && (w_offset == 8'd5)) begin
                r_state     <= StFill;
                r_fill_busy <= 1'b1;
                r_fill_val  <= BUS_DATA_IN[0];
                r_fill_cnt  <= '0;
            end
        end else begin
            r_fill_cnt <= r_fill_cnt + ADDR_WIDTH'(1);
            if (r_fill_cnt == CntLast) begin
                r_state     <= StIdle;
                r_fill_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x       <= 8'h00;
            r_y       <= 7'h00;
            r_colours <= COLOUR_RESET;
        end else if (w_wr) begin
            if (w_offset == 8'd0) r_x <= BUS_DATA_IN;
            if (w_offset == 8'd1) r_y <= BUS_DATA_IN[6:0];
            if (w_offset == 8'd3) r_colours[7:0] <= BUS_DATA_IN;
            if (w_offset == 8'd4) r_colours[15:8] <= BUS_DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dout <= 8'h00;
            r_oe   <= 1'b0;
        end else begin
            r_oe   <= w_rd;
            r_dout <= w_rd ? w_rd_data : 8'h00;
        end
    end

    assign BUS_DATA_OUT   = r_dout;
    assign BUS_DATA_OE    = r_oe;
    assign VGA_DATA       = r_vga;
    assign CONFIG_COLOURS = r_colours;
    assign FILL_BUSY      = r_fill_busy;

endmodule

// File: tb/tb_vga_frame_buffer_if.sv
// Randomised bench for vga_frame_buffer_if: a transaction-level model predicts every output each
// cycle, and directed literal checks pin the model for reset, pixel, fill and abort scenarios.
module tb_vga_frame_buffer_if;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  BUS_ADDR = 8'h00;
    logic [7:0]  BUS_DATA_IN = 8'h00;
    logic        BUS_WE = 1'b0;
    logic        BUS_RE = 1'b0;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_DATA_OE;
    logic        DPR_CLK = 1'b0;
    logic [14:0] VGA_ADDR = 15'h0;
    logic        VGA_DATA;
    logic [15:0] CONFIG_COLOURS;
    logic        FILL_BUSY;

    vga_frame_buffer_if dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .BUS_ADDR       (BUS_ADDR),
        .BUS_DATA_IN    (BUS_DATA_IN),
        .BUS_WE         (BUS_WE),
        .BUS_RE         (BUS_RE),
        .BUS_DATA_OUT   (BUS_DATA_OUT),
        .BUS_DATA_OE    (BUS_DATA_OE),
        .DPR_CLK        (DPR_CLK),
        .VGA_ADDR       (VGA_ADDR),
        .VGA_DATA       (VGA_DATA),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .FILL_BUSY      (FILL_BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: memory contents plus which bits have a defined value.
    bit          m_mem   [32768];
    bit          m_known [32768];
    logic [7:0]  m_x, m_out;
    logic [6:0]  m_y;
    logic [15:0] m_col;
    bit          m_busy, m_fill, m_oe, m_vga, m_out_known, m_vga_known, m_busy_pre;
    int          m_cnt;
    int          cyc = 0;
    bit          model_valid = 0;
    logic [7:0]  m_off;
    logic [14:0] m_pa;

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            m_x = 0; m_y = 0; m_col = 16'hFF00; m_busy = 0; m_cnt = 0;
            m_oe = 0; m_out = 0; m_out_known = 1; m_vga = 0; m_vga_known = 1;
            model_valid = 1;
        end else begin
            m_off = BUS_ADDR - 8'hB0;
            m_pa = {m_y, m_x};
            m_busy_pre = m_busy;
            if (DPR_CLK) begin
                m_vga = m_mem[VGA_ADDR];
                m_vga_known = m_known[VGA_ADDR];
            end
            m_oe = 0; m_out = 0; m_out_known = 1;
            if (BUS_RE && !BUS_WE && m_off < 6) begin
                m_oe = 1;
                case (m_off)
                    0: m_out = m_x;
                    1: m_out = {1'b0, m_y};
                    2: if (!m_busy_pre) begin
                        m_out = {7'b0, m_mem[m_pa]};
                        m_out_known = m_known[m_pa];
                    end
                    3: m_out = m_col[7:0];
                    4: m_out = m_col[15:8];
                    default: m_out = {7'b0, m_busy_pre};
                endcase
            end
            if (m_busy_pre) begin
                m_mem[m_cnt] = m_fill;
                m_known[m_cnt] = 1;
                m_cnt++;
                if (m_cnt == 32768) m_busy = 0;
            end
            if (BUS_WE && m_off < 6) begin
                case (m_off)
                    0: m_x = BUS_DATA_IN;
                    1: m_y = BUS_DATA_IN[6:0];
                    2: if (!m_busy_pre) begin
                        m_mem[m_pa] = BUS_DATA_IN[0];
                        m_known[m_pa] = 1;
                    end
                    3: m_col[7:0] = BUS_DATA_IN;
                    4: m_col[15:8] = BUS_DATA_IN;
                    default: if (!m_busy_pre) begin
                        m_busy = 1; m_cnt = 0; m_fill = BUS_DATA_IN[0];
                    end
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (model_valid) begin
            chk("oe", {15'b0, BUS_DATA_OE}, {15'b0, m_oe});
            if (m_out_known) chk("dout", {8'b0, BUS_DATA_OUT}, {8'b0, m_out});
            if (m_vga_known) chk("vga", {15'b0, VGA_DATA}, {15'b0, m_vga});
            chk("busy", {15'b0, FILL_BUSY}, {15'b0, m_busy});
            chk("colours", CONFIG_COLOURS, m_col);
        end
    end

    // VGA-side stimulus: one read pulse every fourth cycle, address random unless pinned.
    bit          vga_force = 0;
    logic [14:0] vga_force_addr = 15'h0;
    int          dpr_cnt = 0;
    always @(negedge CLK) begin
        dpr_cnt++;
        DPR_CLK = (dpr_cnt % 4 == 0);
        VGA_ADDR = vga_force ? vga_force_addr : 15'($urandom);
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        BUS_ADDR = a; BUS_DATA_IN = d; BUS_WE = 1;
        @(negedge CLK);
        BUS_WE = 0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge CLK);
        BUS_ADDR = a; BUS_RE = 1;
        @(negedge CLK);
        BUS_RE = 0;
        d = BUS_DATA_OUT;
        oe = BUS_DATA_OE;
    endtask

    task automatic pix_read(input logic [14:0] a, output logic [7:0] d);
        logic oe;
        bus_write(8'hB0, a[7:0]);
        bus_write(8'hB1, {1'b0, a[14:8]});
        bus_read(8'hB2, d, oe);
    endtask

    task automatic vga_peek(input logic [14:0] a, input string name, input bit exp);
        vga_force_addr = a;
        vga_force = 1;
        repeat (6) @(negedge CLK);
        chk(name, {15'b0, VGA_DATA}, {15'b0, exp});
        vga_force = 0;
    endtask

    task automatic random_ops(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            r = int'($urandom_range(0, 7));
            BUS_ADDR = (r < 6) ? 8'hB0 + 8'(r) : ((r == 6) ? 8'hC0 : 8'hAF);
            BUS_WE = ($urandom_range(0, 2) == 0) && (r != 5);
            BUS_RE = !BUS_WE || ($urandom_range(0, 3) == 0);
            if (r == 0) BUS_DATA_IN = 8'($urandom_range(0, 3));
            else if (r == 1) BUS_DATA_IN = 8'($urandom_range(0, 1));
            else BUS_DATA_IN = 8'($urandom);
        end
        @(negedge CLK);
        BUS_WE = 0; BUS_RE = 0;
    endtask

    logic [7:0] d;
    logic       oe;
    int         c0, g;

    initial begin
        repeat (3) @(negedge CLK);
        RESET = 0;

        bus_read(8'hB3, d, oe);
        chk("rst_col_lo_oe", {15'b0, oe}, 16'h1);
        chk("rst_col_lo", {8'b0, d}, 16'h0000);
        @(negedge CLK);
        chk("oe_one_cycle", {15'b0, BUS_DATA_OE}, 16'h0);
        bus_read(8'hB4, d, oe);
        chk("rst_col_hi_oe", {15'b0, oe}, 16'h1);
        chk("rst_col_hi", {8'b0, d}, 16'h00FF);
        chk("rst_colours", CONFIG_COLOURS, 16'hFF00);

        bus_write(8'hB0, 8'h25);
        bus_write(8'hB1, 8'h3A);
        bus_write(8'hB2, 8'h01);
        bus_read(8'hB2, d, oe);
        chk("pixel_rd", {8'b0, d}, 16'h0001);
        vga_peek(15'h3A25, "vga_pixel", 1'b1);

        random_ops(300);

        bus_write(8'hB0, 8'h00);
        bus_write(8'hB1, 8'h00);
        bus_write(8'hB5, 8'h01);
        c0 = cyc;
        bus_write(8'hB2, 8'h00);
        bus_read(8'hB2, d, oe);
        chk("fill_pix_rd", {7'b0, oe, d}, 16'h0100);
        bus_write(8'hB5, 8'h00);
        g = 0;
        while (FILL_BUSY && g < 40000) begin
            @(negedge CLK);
            g++;
        end
        chk("fill_len", 16'(cyc - c0), 16'(32768));
        bus_read(8'hB2, d, oe);
        chk("fill_loc0", {8'b0, d}, 16'h0001);
        vga_peek(15'h0000, "vga_0000", 1'b1);
        vga_peek(15'h4ABC, "vga_4abc", 1'b1);
        vga_peek(15'h7FFF, "vga_7fff", 1'b1);

        random_ops(300);

        bus_write(8'hB5, 8'h00);
        c0 = cyc;
        g = 0;
        while (cyc != c0 + 999 && g < 2000) begin
            @(negedge CLK);
            g++;
        end
        RESET = 1;
        @(negedge CLK);
        chk("abort_busy", {15'b0, FILL_BUSY}, 16'h0);
        RESET = 0;
        pix_read(15'd0, d);
        chk("abort_loc0", {8'b0, d}, 16'h0000);
        pix_read(15'd500, d);
        chk("abort_loc500", {8'b0, d}, 16'h0000);
        pix_read(15'd998, d);
        chk("abort_loc998", {8'b0, d}, 16'h0000);
        pix_read(15'd20000, d);
        chk("abort_loc20000", {8'b0, d}, 16'h0001);

        @(negedge CLK);
        BUS_ADDR = 8'hB3; BUS_DATA_IN = 8'h1C; BUS_WE = 1; BUS_RE = 1;
        @(negedge CLK);
        BUS_WE = 0; BUS_RE = 0;
        chk("wr_rd_oe", {15'b0, BUS_DATA_OE}, 16'h0);
        chk("wr_rd_col", {8'b0, CONFIG_COLOURS[7:0]}, 16'h001C);
        bus_read(8'hC0, d, oe);
        chk("oor_oe", {15'b0, oe}, 16'h0);
        chk("oor_dout", {8'b0, d}, 16'h0000);

        random_ops(300);
        repeat (4) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_frame_buffer_if.md
Name: vga_frame_buffer_if

Overview:
- Memory-mapped bridge between the microprocessor data bus and the VGA signal generator.
- Holds the 32768 x 1-bit frame buffer (dual-port; processor/fill side and VGA read side) and the 16-bit colour configuration register.
- Includes a hardware clear/fill engine that writes one value to every location, so software does not have to loop over pixels.
- Sits directly upstream of the VGA signal generator and drives its VGA_DATA and CONFIG_COLOURS inputs.

Parameters:
- BASE_ADDR, 8'hB0, bus address of register 0; six consecutive addresses are decoded.
- ADDR_WIDTH, 15, frame buffer address width; depth is 2^ADDR_WIDTH.
- COLOUR_RESET, 16'hFF00, reset value of CONFIG_COLOURS.

Ports:
- CLK  input  1  system clock, 100 MHz; the only clock.
- RESET  input  1  synchronous, active-high reset.
- BUS_ADDR  input  8  processor bus address.
- BUS_DATA_IN  input  8  processor write data.
- BUS_WE  input  1  write strobe, one cycle per access.
- BUS_RE  input  1  read strobe, one cycle per access.
- BUS_DATA_OUT  output  8  read data, valid the cycle after BUS_RE.
- BUS_DATA_OE  output  1  high for exactly the cycle BUS_DATA_OUT is valid and addressed to this block.
- DPR_CLK  input  1  VGA read enable pulse, one CLK cycle in four, from the signal generator.
- VGA_ADDR  input  15  VGA read address {row[6:0], col[7:0]}.
- VGA_DATA  output  1  registered frame-buffer bit for VGA_ADDR.
- CONFIG_COLOURS  output  16  [7:0] colour for bit 0, [15:8] colour for bit 1.
- FILL_BUSY  output  1  high while the fill engine runs.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0: X = address bits [7:0], read/write.
  - 1: Y = address bits [14:8] (BUS_DATA_IN[6:0]); reads as {1'b0, Y}.
  - 2: PIXEL. A write stores BUS_DATA_IN[0] at {Y,X}. A read returns {7'b0, mem[{Y,X}]}.
  - 3: CONFIG_COLOURS[7:0], read/write.
  - 4: CONFIG_COLOURS[15:8], read/write.
  - 5: CTRL. A write starts a fill with value BUS_DATA_IN[0]. A read returns {7'b0, FILL_BUSY}.
- Addresses outside the six-register window are ignored. BUS_DATA_OE stays 0 and BUS_DATA_OUT holds 0.
- Reset values:
  - X = 0, Y = 0.
  - CONFIG_COLOURS = COLOUR_RESET.
  - FILL_BUSY = 0, fill counter = 0.
  - BUS_DATA_OUT = 0, BUS_DATA_OE = 0, VGA_DATA = 0.
  - RAM contents are not cleared by reset.
- Write latency:
  - Register writes take effect on the CLK edge where BUS_WE is sampled high.
  - A PIXEL write is visible to a PIXEL read issued in the next cycle.
- Read latency is exactly 1 cycle. BUS_DATA_OUT and BUS_DATA_OE update on the edge after BUS_RE, and BUS_DATA_OE returns low the following cycle unless BUS_RE is repeated. Back-to-back reads are supported, one per cycle.
- If BUS_WE and BUS_RE are high in the same cycle, the write is performed and the read is dropped (no OE).
- VGA port:
  - On each CLK edge with DPR_CLK = 1, VGA_DATA <= mem[VGA_ADDR].
  - Otherwise VGA_DATA holds.
  - This port never stalls and is unaffected by processor or fill activity.
  - When the VGA read and a port-A write hit the same address in the same cycle, VGA_DATA returns the old data.
- Fill FSM, states IDLE and FILL:
  - IDLE -> FILL on a CTRL write. This latches the fill value, clears the counter and sets FILL_BUSY on the same edge.
  - In FILL, one location is written per cycle at address = counter, then the counter increments. Duration is 2^ADDR_WIDTH cycles (32768).
  - FILL -> IDLE on the edge that writes address 2^ADDR_WIDTH-1. FILL_BUSY is low from the next cycle.
  - Every address is written exactly once; no wrap.
- During FILL:
  - Port A is owned by the fill engine. PIXEL writes are discarded.
  - PIXEL reads return 8'h00, with OE asserted normally.
  - CTRL writes are ignored; no restart.
  - X, Y and colour registers remain writable and readable.
- RESET during FILL aborts immediately: state goes to IDLE, FILL_BUSY to 0. Locations already written keep the fill value; the rest are unchanged.

Test Plan:
- Reset, then read offsets 3 and 4 -> 8'h00 and 8'hFF with BUS_DATA_OE high exactly one cycle after each BUS_RE. CONFIG_COLOURS = 16'hFF00.
- Write X = 8'h25, Y = 8'h3A, PIXEL = 1, then read PIXEL next cycle -> BUS_DATA_OUT = 8'h01. Hold VGA_ADDR = 15'h3A25 and pulse DPR_CLK -> VGA_DATA = 1 on the following edge.
- Write CTRL = 8'h01 -> FILL_BUSY high for exactly 32768 cycles. Afterwards, VGA reads at 15'h0000, 15'h4ABC and 15'h7FFF all return 1.
- During a fill, write PIXEL = 0 at {Y,X} = 15'h0000 and read PIXEL -> read returns 8'h00. After the fill, location 0 reads 1 (write discarded). A CTRL write mid-fill does not extend the busy time.
- Start a fill with value 0, assert RESET at cycle 1000 -> FILL_BUSY drops on the reset edge. Locations 0-998 read 0; location 20000 retains its prior value 1.
- Same-cycle BUS_WE and BUS_RE to offset 3 with data 8'h1C -> CONFIG_COLOURS[7:0] = 8'h1C, BUS_DATA_OE stays 0. A read of offset 8'hC0 (out of range) -> OE stays 0.
